// File: rtl/id_ex_if.sv
// Bundle of Decode, Memory/Writeback forwarding and Execute-stage signals
// exchanged with the decode-to-execute pipeline register.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // Decode-side controls and operands
    logic              stallE;
    logic              flushE;
    logic              validD;
    logic [3:0]        ra1D;
    logic [3:0]        ra2D;
    logic [DATA_W-1:0] rd1D;
    logic [DATA_W-1:0] rd2D;
    logic [3:0]        wa3D;
    logic [DATA_W-1:0] immD;
    logic              regWriteD;
    logic              memToRegD;
    logic              memWriteD;
    logic [2:0]        aluControlD;

    // Younger results available for forwarding
    logic [3:0]        wa3M;
    logic              regWriteM;
    logic [DATA_W-1:0] aluResultM;
    logic [3:0]        wa3W;
    logic              regWriteW;
    logic [DATA_W-1:0] resultW;

    // Execute-stage view
    logic              validE;
    logic              regWriteE;
    logic              memToRegE;
    logic              memWriteE;
    logic [2:0]        aluControlE;
    logic [3:0]        wa3E;
    logic [DATA_W-1:0] immE;
    logic [DATA_W-1:0] srcAE;
    logic [DATA_W-1:0] srcBE;
    logic [1:0]        fwdAE;
    logic [1:0]        fwdBE;
    logic              loadUseStall;
    logic [CNT_W-1:0]  stallCount;

    modport master (
        output stallE, flushE, validD, ra1D, ra2D, rd1D, rd2D, wa3D, immD,
               regWriteD, memToRegD, memWriteD, aluControlD,
               wa3M, regWriteM, aluResultM, wa3W, regWriteW, resultW,
        input  validE, regWriteE, memToRegE, memWriteE, aluControlE, wa3E, immE,
               srcAE, srcBE, fwdAE, fwdBE, loadUseStall, stallCount
    );

    modport slave (
        input  stallE, flushE, validD, ra1D, ra2D, rd1D, rd2D, wa3D, immD,
               regWriteD, memToRegD, memWriteD, aluControlD,
               wa3M, regWriteM, aluResultM, wa3W, regWriteW, resultW,
        output validE, regWriteE, memToRegE, memWriteE, aluControlE, wa3E, immE,
               srcAE, srcBE, fwdAE, fwdBE, loadUseStall, stallCount
    );
endinterface

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with M/W operand forwarding,
// load-use bubble insertion and a saturating stall-cycle counter.
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic   clk,
    input  logic   reset,
    id_ex_if.slave bus
);
    // Register 9 reads as PC+8 and is never a real forwarding/hazard target
    localparam logic [3:0] PC_REG = 4'd9;

    logic              valid_reg;
    logic              reg_write_reg;
    logic              mem_to_reg_reg;
    logic              mem_write_reg;
    logic [2:0]        alu_control_reg;
    logic [3:0]        wa3_reg;
    logic [DATA_W-1:0] imm_reg;
    logic [CNT_W-1:0]  stall_count_reg;

    logic              load_use;
    logic              bubble;
    logic              load;

    logic [3:0]        ra_d  [2];
    logic [DATA_W-1:0] rd_d  [2];
    logic [DATA_W-1:0] src   [2];
    logic [1:0]        fwd   [2];

    assign ra_d[0] = bus.ra1D;
    assign ra_d[1] = bus.ra2D;
    assign rd_d[0] = bus.rd1D;
    assign rd_d[1] = bus.rd2D;

    assign load_use = bus.validD && valid_reg && mem_to_reg_reg && (wa3_reg != PC_REG)
                      && ((bus.ra1D == wa3_reg) || (bus.ra2D == wa3_reg));

    // flushE outranks stallE, which in turn outranks the load-use bubble
    assign bubble = bus.flushE || (!bus.stallE && load_use);
    assign load   = !bus.flushE && !bus.stallE && !load_use;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg      <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
        end else if (bubble) begin
            valid_reg      <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
        end else if (load) begin
            valid_reg      <= bus.validD;
            reg_write_reg  <= bus.regWriteD;
            mem_to_reg_reg <= bus.memToRegD;
            mem_write_reg  <= bus.memWriteD;
        end
    end

    // Data fields are left untouched by a bubble; only a real load replaces them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_control_reg <= 3'd0;
            wa3_reg         <= 4'd0;
            imm_reg         <= '0;
        end else if (load) begin
            alu_control_reg <= bus.aluControlD;
            wa3_reg         <= bus.wa3D;
            imm_reg         <= bus.immD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_reg <= '0;
        end else if (load_use && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_reg <= stall_count_reg + CNT_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic [3:0]        ra_reg;
            logic [DATA_W-1:0] rd_reg;
            logic              hit_m;
            logic              hit_w;
            logic [DATA_W-1:0] src_next;
            logic [1:0]        fwd_next;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ra_reg <= 4'd0;
                    rd_reg <= '0;
                end else if (load) begin
                    ra_reg <= ra_d[gi];
                    rd_reg <= rd_d[gi];
                end
            end

            assign hit_m = bus.regWriteM && (bus.wa3M == ra_reg) && (ra_reg != PC_REG);
            assign hit_w = bus.regWriteW && (bus.wa3W == ra_reg) && (ra_reg != PC_REG);

            // Memory wins over Writeback: it carries the younger value
            always_comb begin
                src_next = rd_reg;
                fwd_next = 2'b00;
                if (hit_m) begin
                    src_next = bus.aluResultM;
                    fwd_next = 2'b10;
                end else if (hit_w) begin
                    src_next = bus.resultW;
                    fwd_next = 2'b01;
                end
            end

            assign src[gi] = src_next;
            assign fwd[gi] = fwd_next;
        end
    endgenerate

    assign bus.validE       = valid_reg;
    assign bus.regWriteE    = reg_write_reg;
    assign bus.memToRegE    = mem_to_reg_reg;
    assign bus.memWriteE    = mem_write_reg;
    assign bus.aluControlE  = alu_control_reg;
    assign bus.wa3E         = wa3_reg;
    assign bus.immE         = imm_reg;
    assign bus.srcAE        = src[0];
    assign bus.srcBE        = src[1];
    assign bus.fwdAE        = fwd[0];
    assign bus.fwdBE        = fwd[1];
    assign bus.loadUseStall = load_use;
    assign bus.stallCount   = stall_count_reg;
endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, load, forwarding, load-use,
// register-9 exclusion, flush/stall priority and counter saturation.
module tb_id_ex_reg;
    logic clk;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;

    id_ex_if #(.DATA_W(32), .CNT_W(16)) bus ();

    id_ex_reg #(.DATA_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic clear_inputs;
        bus.stallE = 0; bus.flushE = 0; bus.validD = 0;
        bus.ra1D = 0; bus.ra2D = 0; bus.rd1D = 0; bus.rd2D = 0;
        bus.wa3D = 0; bus.immD = 0; bus.regWriteD = 0; bus.memToRegD = 0;
        bus.memWriteD = 0; bus.aluControlD = 0;
        bus.wa3M = 0; bus.regWriteM = 0; bus.aluResultM = 0;
        bus.wa3W = 0; bus.regWriteW = 0; bus.resultW = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        bus.stallE = 0; bus.flushE = 0; bus.validD = 1;
        bus.ra1D = 4; bus.ra2D = 5; bus.rd1D = 32'hDEADBEEF; bus.rd2D = 32'hCAFEF00D;
        bus.wa3D = 7; bus.immD = 32'h1234; bus.regWriteD = 1; bus.memToRegD = 1;
        bus.memWriteD = 1; bus.aluControlD = 3'b111;
        bus.wa3M = 12; bus.regWriteM = 1; bus.aluResultM = 32'h5555;
        bus.wa3W = 13; bus.regWriteW = 1; bus.resultW = 32'h6666;
        tick; tick;
        n_vec++; if (bus.validE !== 1'b0) begin n_fail++; $display("FAIL reset_validE got %b exp 0", bus.validE); end
        n_vec++; if (bus.regWriteE !== 1'b0) begin n_fail++; $display("FAIL reset_regWriteE got %b exp 0", bus.regWriteE); end
        n_vec++; if (bus.memToRegE !== 1'b0) begin n_fail++; $display("FAIL reset_memToRegE got %b exp 0", bus.memToRegE); end
        n_vec++; if (bus.memWriteE !== 1'b0) begin n_fail++; $display("FAIL reset_memWriteE got %b exp 0", bus.memWriteE); end
        n_vec++; if (bus.aluControlE !== 3'd0) begin n_fail++; $display("FAIL reset_aluControlE got %0d exp 0", bus.aluControlE); end
        n_vec++; if (bus.wa3E !== 4'd0) begin n_fail++; $display("FAIL reset_wa3E got %0d exp 0", bus.wa3E); end
        n_vec++; if (bus.immE !== 32'h0) begin n_fail++; $display("FAIL reset_immE got %h exp 0", bus.immE); end
        n_vec++; if (bus.srcAE !== 32'h0 || bus.fwdAE !== 2'b00) begin n_fail++; $display("FAIL reset_srcA got %h/%b exp 0/00", bus.srcAE, bus.fwdAE); end
        n_vec++; if (bus.srcBE !== 32'h0 || bus.fwdBE !== 2'b00) begin n_fail++; $display("FAIL reset_srcB got %h/%b exp 0/00", bus.srcBE, bus.fwdBE); end
        n_vec++; if (bus.loadUseStall !== 1'b0) begin n_fail++; $display("FAIL reset_loadUse got %b exp 0", bus.loadUseStall); end
        n_vec++; if (bus.stallCount !== 16'h0) begin n_fail++; $display("FAIL reset_stallCount got %h exp 0", bus.stallCount); end
        reset = 0;
        bus.memToRegD = 0;
        tick;
        n_vec++; if (bus.validE !== 1'b1 || bus.immE !== 32'h1234) begin n_fail++; $display("FAIL reset_release_load got %b/%h exp 1/00001234", bus.validE, bus.immE); end
        #2 reset = 1;
        #1;
        n_vec++; if (bus.validE !== 1'b0) begin n_fail++; $display("FAIL async_reset_validE got %b exp 0", bus.validE); end
        n_vec++; if (bus.immE !== 32'h0 || bus.wa3E !== 4'd0) begin n_fail++; $display("FAIL async_reset_fields got %h/%0d exp 0/0", bus.immE, bus.wa3E); end
        n_vec++; if (bus.srcAE !== 32'h0) begin n_fail++; $display("FAIL async_reset_srcA got %h exp 0", bus.srcAE); end
        tick;
        reset = 0;
        clear_inputs;
        $display("test_reset done");
    endtask

    task automatic test_plain_load;
        clear_inputs;
        bus.validD = 1; bus.ra1D = 2; bus.rd1D = 32'h11; bus.ra2D = 3; bus.rd2D = 32'h22;
        bus.immD = 32'h40; bus.regWriteD = 1; bus.aluControlD = 3'b101; bus.wa3D = 4;
        tick;
        clear_inputs;
        settle;
        n_vec++; if (bus.srcAE !== 32'h11 || bus.fwdAE !== 2'b00) begin n_fail++; $display("FAIL plain_srcA got %h/%b exp 00000011/00", bus.srcAE, bus.fwdAE); end
        n_vec++; if (bus.srcBE !== 32'h22 || bus.fwdBE !== 2'b00) begin n_fail++; $display("FAIL plain_srcB got %h/%b exp 00000022/00", bus.srcBE, bus.fwdBE); end
        n_vec++; if (bus.immE !== 32'h40) begin n_fail++; $display("FAIL plain_immE got %h exp 00000040", bus.immE); end
        n_vec++; if (bus.regWriteE !== 1'b1 || bus.validE !== 1'b1) begin n_fail++; $display("FAIL plain_ctrl got rw=%b v=%b exp 1/1", bus.regWriteE, bus.validE); end
        n_vec++; if (bus.aluControlE !== 3'b101 || bus.wa3E !== 4'd4 || bus.memToRegE !== 1'b0) begin n_fail++; $display("FAIL plain_fields got alu=%0d wa3=%0d m2r=%b exp 5/4/0", bus.aluControlE, bus.wa3E, bus.memToRegE); end
        $display("test_plain_load done");
    endtask

    task automatic test_forward_priority;
        clear_inputs;
        bus.validD = 1; bus.ra1D = 3; bus.rd1D = 32'h33; bus.ra2D = 3; bus.rd2D = 32'h44;
        tick;
        clear_inputs;
        bus.regWriteM = 1; bus.wa3M = 3; bus.aluResultM = 32'hAA;
        bus.regWriteW = 1; bus.wa3W = 3; bus.resultW = 32'hBB;
        settle;
        n_vec++; if (bus.srcAE !== 32'hAA || bus.fwdAE !== 2'b10) begin n_fail++; $display("FAIL fwd_both_A got %h/%b exp 000000aa/10", bus.srcAE, bus.fwdAE); end
        n_vec++; if (bus.srcBE !== 32'hAA || bus.fwdBE !== 2'b10) begin n_fail++; $display("FAIL fwd_both_B got %h/%b exp 000000aa/10", bus.srcBE, bus.fwdBE); end
        bus.regWriteM = 0;
        settle;
        n_vec++; if (bus.srcAE !== 32'hBB || bus.fwdAE !== 2'b01) begin n_fail++; $display("FAIL fwd_w_A got %h/%b exp 000000bb/01", bus.srcAE, bus.fwdAE); end
        bus.regWriteM = 1; bus.wa3M = 4;
        bus.regWriteW = 0;
        settle;
        n_vec++; if (bus.srcAE !== 32'h33 || bus.fwdAE !== 2'b00) begin n_fail++; $display("FAIL fwd_none_A got %h/%b exp 00000033/00", bus.srcAE, bus.fwdAE); end
        n_vec++; if (bus.srcBE !== 32'h44 || bus.fwdBE !== 2'b00) begin n_fail++; $display("FAIL fwd_none_B got %h/%b exp 00000044/00", bus.srcBE, bus.fwdBE); end
        clear_inputs;
        $display("test_forward_priority done");
    endtask

    task automatic test_load_use;
        clear_inputs;
        bus.validD = 1; bus.memToRegD = 1; bus.regWriteD = 1; bus.wa3D = 5; bus.ra1D = 1; bus.ra2D = 2;
        tick;
        clear_inputs;
        bus.validD = 1; bus.regWriteD = 1; bus.wa3D = 8; bus.ra1D = 7; bus.rd1D = 32'h77;
        bus.ra2D = 5; bus.rd2D = 32'h55;
        settle;
        n_vec++; if (bus.loadUseStall !== 1'b1) begin n_fail++; $display("FAIL lu_detect got %b exp 1", bus.loadUseStall); end
        tick;
        n_vec++; if (bus.validE !== 1'b0 || bus.regWriteE !== 1'b0 || bus.memToRegE !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got v=%b rw=%b m2r=%b exp 0/0/0", bus.validE, bus.regWriteE, bus.memToRegE); end
        n_vec++; if (bus.stallCount !== 16'd1) begin n_fail++; $display("FAIL lu_count got %0d exp 1", bus.stallCount); end
        n_vec++; if (bus.loadUseStall !== 1'b0) begin n_fail++; $display("FAIL lu_release got %b exp 0", bus.loadUseStall); end
        bus.regWriteM = 1; bus.wa3M = 5; bus.aluResultM = 32'h99;
        tick;
        n_vec++; if (bus.validE !== 1'b1 || bus.wa3E !== 4'd8) begin n_fail++; $display("FAIL lu_dep_loaded got v=%b wa3=%0d exp 1/8", bus.validE, bus.wa3E); end
        n_vec++; if (bus.srcBE !== 32'h99 || bus.fwdBE !== 2'b10) begin n_fail++; $display("FAIL lu_fwd_B got %h/%b exp 00000099/10", bus.srcBE, bus.fwdBE); end
        n_vec++; if (bus.srcAE !== 32'h77 || bus.fwdAE !== 2'b00) begin n_fail++; $display("FAIL lu_srcA got %h/%b exp 00000077/00", bus.srcAE, bus.fwdAE); end
        n_vec++; if (bus.stallCount !== 16'd1) begin n_fail++; $display("FAIL lu_count_hold got %0d exp 1", bus.stallCount); end
        clear_inputs;
        $display("test_load_use done");
    endtask

    task automatic test_reg9_and_priority;
        clear_inputs;
        bus.validD = 1; bus.memToRegD = 1; bus.regWriteD = 1; bus.wa3D = 9;
        tick;
        clear_inputs;
        bus.validD = 1; bus.ra1D = 9; bus.ra2D = 9; bus.rd1D = 32'h108; bus.rd2D = 32'h108;
        bus.regWriteD = 1; bus.wa3D = 2; bus.immD = 32'h5;
        bus.regWriteM = 1; bus.wa3M = 9; bus.aluResultM = 32'hDEAD;
        bus.regWriteW = 1; bus.wa3W = 9; bus.resultW = 32'hBEEF;
        settle;
        n_vec++; if (bus.loadUseStall !== 1'b0) begin n_fail++; $display("FAIL r9_no_stall got %b exp 0", bus.loadUseStall); end
        tick;
        n_vec++; if (bus.srcAE !== 32'h108 || bus.fwdAE !== 2'b00) begin n_fail++; $display("FAIL r9_no_fwd_A got %h/%b exp 00000108/00", bus.srcAE, bus.fwdAE); end
        n_vec++; if (bus.srcBE !== 32'h108 || bus.fwdBE !== 2'b00) begin n_fail++; $display("FAIL r9_no_fwd_B got %h/%b exp 00000108/00", bus.srcBE, bus.fwdBE); end
        bus.immD = 32'h6; bus.stallE = 1;
        tick;
        n_vec++; if (bus.immE !== 32'h5 || bus.validE !== 1'b1) begin n_fail++; $display("FAIL stall_hold got imm=%h v=%b exp 00000005/1", bus.immE, bus.validE); end
        bus.flushE = 1;
        tick;
        n_vec++; if (bus.validE !== 1'b0 || bus.regWriteE !== 1'b0) begin n_fail++; $display("FAIL flush_over_stall got v=%b rw=%b exp 0/0", bus.validE, bus.regWriteE); end
        n_vec++; if (bus.immE !== 32'h5) begin n_fail++; $display("FAIL flush_keeps_data got %h exp 00000005", bus.immE); end
        clear_inputs;
        $display("test_reg9_and_priority done");
    endtask

    task automatic test_flush_with_load_use;
        clear_inputs;
        bus.validD = 1; bus.memToRegD = 1; bus.regWriteD = 1; bus.wa3D = 6;
        tick;
        clear_inputs;
        bus.validD = 1; bus.ra1D = 6; bus.flushE = 1;
        settle;
        n_vec++; if (bus.loadUseStall !== 1'b1) begin n_fail++; $display("FAIL flu_detect got %b exp 1", bus.loadUseStall); end
        tick;
        n_vec++; if (bus.validE !== 1'b0 || bus.memToRegE !== 1'b0) begin n_fail++; $display("FAIL flu_bubble got v=%b m2r=%b exp 0/0", bus.validE, bus.memToRegE); end
        n_vec++; if (bus.stallCount !== 16'd2) begin n_fail++; $display("FAIL flu_count got %0d exp 2", bus.stallCount); end
        clear_inputs;
        $display("test_flush_with_load_use done");
    endtask

    task automatic test_saturation;
        clear_inputs;
        bus.validD = 1; bus.memToRegD = 1; bus.regWriteD = 1; bus.wa3D = 5;
        tick;
        clear_inputs;
        bus.validD = 1; bus.ra1D = 5; bus.stallE = 1;
        repeat (100) tick;
        n_vec++; if (bus.stallCount !== 16'd102) begin n_fail++; $display("FAIL sat_partial got %0d exp 102", bus.stallCount); end
        n_vec++; if (bus.loadUseStall !== 1'b1 || bus.memToRegE !== 1'b1 || bus.validE !== 1'b1) begin n_fail++; $display("FAIL sat_load_held got lu=%b m2r=%b v=%b exp 1/1/1", bus.loadUseStall, bus.memToRegE, bus.validE); end
        repeat (65440) tick;
        n_vec++; if (bus.stallCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat_full got %h exp ffff", bus.stallCount); end
        tick;
        n_vec++; if (bus.stallCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat_stays got %h exp ffff", bus.stallCount); end
        clear_inputs;
        $display("test_saturation done");
    endtask

    initial begin
        reset = 1;
        clear_inputs;
        test_reset;
        test_plain_load;
        test_forward_priority;
        test_load_use;
        test_reg9_and_priority;
        test_flush_with_load_use;
        test_saturation;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Decode-to-execute pipeline register that sits directly downstream of the register file. Captures the two register-file read values, the decoded immediate and the control bundle at the end of Decode, and presents them to Execute. Also resolves data hazards: it forwards results from Memory/Writeback into the Execute operands, detects load-use hazards, and inserts bubbles. A saturating counter records stall cycles for performance debug.

## Interface
- DATA_W, 32, operand and immediate width
- CNT_W, 16, stall-counter width

- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- stallE  in  1  hold the E-stage contents
- flushE  in  1  replace the E-stage contents with a bubble
- validD  in  1  Decode holds a real instruction
- ra1D, ra2D  in  4  source register addresses, as sent to the register file
- rd1D, rd2D  in  DATA_W  register-file read data; address 9 already yields PC+8
- wa3D  in  4  destination register
- immD  in  DATA_W  extended immediate
- regWriteD, memToRegD, memWriteD  in  1 each  control bits
- aluControlD  in  3  ALU operation
- wa3M, regWriteM  in  4 / 1  Memory-stage destination and write enable
- aluResultM  in  DATA_W  Memory-stage ALU result
- wa3W, regWriteW  in  4 / 1  Writeback-stage destination and write enable
- resultW  in  DATA_W  Writeback result, the same value driven to the register file's writeData
- validE, regWriteE, memToRegE, memWriteE  out  1  registered control
- aluControlE  out  3  registered ALU operation
- wa3E  out  4  registered destination
- immE  out  DATA_W  registered immediate
- srcAE, srcBE  out  DATA_W  forwarded operands
- fwdAE, fwdBE  out  2  forward select: 00 = register file, 01 = Writeback, 10 = Memory
- loadUseStall  out  1  combinational; stall Fetch and Decode this cycle
- stallCount  out  CNT_W  saturating count of cycles with loadUseStall high

## Operation
- **Register update priority**, evaluated each rising edge:
  1. reset
  2. flushE → bubble
  3. stallE → hold
  4. loadUseStall → bubble
  5. otherwise load the D-stage inputs
- **Bubble:**
  - validE, regWriteE, memToRegE and memWriteE all go to 0.
  - The data fields, ra1E/ra2E (internal copies of the source addresses) and wa3E keep their old values; they are don't-care.
- **Hazard (Memory stage):** hitM(x) = regWriteM && wa3M==x && x!=4'd9.
- **Hazard (Writeback stage):** hitW(x) = regWriteW && wa3W==x && x!=4'd9.
- **Operand A selection**, in priority order:
  1. hitM(ra1E) → srcAE = aluResultM, fwdAE = 10.
  2. Else hitW(ra1E) → srcAE = resultW, fwdAE = 01.
  3. Else srcAE = rd1E, fwdAE = 00.
- **Operand B selection:** identical, using ra2E, rd2E, srcBE and fwdBE.
- Register 9 is never forwarded; it is read-only PC+8.
- **Load-use stall:** loadUseStall = validD && validE && memToRegE && wa3E!=9 && (ra1D==wa3E || ra2D==wa3E).
- **Stall counter:** increments on each rising edge where loadUseStall=1, and saturates at all-ones.

## Timing
- **Reset values:** validE, regWriteE, memToRegE, memWriteE, aluControlE, wa3E, immE, rd1E/rd2E, ra1E/ra2E and stallCount are all 0.
  - Consequently srcAE/srcBE = 0 unless a forward hits; fwd = 00 under the same condition.
  - Reset asserted mid-operation clears these immediately, without waiting for a clock.
- **Latency:**
  - D→E register: 1 cycle.
  - Forwarding muxes and loadUseStall: 0 cycles, combinational.
- **loadUseStall with stallE:**
  - If stallE=1, E holds, so the load stays in E.
  - loadUseStall can remain asserted; stallCount keeps counting.
- **flushE and loadUseStall together:** bubble inserted; the counter still increments.
- **Upstream contract:** while loadUseStall=1, upstream must hold Fetch/Decode. The next cycle the load has moved to M, and the dependency resolves through hitM.
- **Forward match in both M and W:** M wins (it holds the younger value).
- **Writes to register 9:** destination 9 never matches for forwarding or for the load-use check.

## Test plan
- **Reset:** reset=1 with arbitrary inputs → all outputs 0 and stallCount=0, asserted asynchronously mid-cycle.
- **Plain load:** load ra1D=2, rd1D=0x11, immD=0x40, regWriteD=1, no hazards → next cycle srcAE=0x11, immE=0x40, regWriteE=1, fwdAE=00.
- **Forward priority:** E holds ra1E=3; regWriteM=1, wa3M=3, aluResultM=0xAA; regWriteW=1, wa3W=3, resultW=0xBB → srcAE=0xAA, fwdAE=10.
  - Then drop regWriteM → srcAE=0xBB, fwdAE=01.
- **Load-use:**
  - E holds a load with wa3E=5; D has ra2D=5 → loadUseStall=1.
  - Next cycle: validE=0, regWriteE=0, stallCount=1.
  - Then, with the load in M (hitM), srcBE=aluResultM.
- **Register 9 and priority:**
  - wa3E=9 load with ra1D=9 → loadUseStall=0.
  - wa3M=9 with ra1E=9 → srcAE=rd1E.
  - flushE=1 with stallE=1 → bubble.
- **Counter saturation:** hold loadUseStall=1 (validD=1, stallE=1) for 65540 cycles → stallCount=0xFFFF.
